// File: rtl/adder_result_checker.sv
// Adder result checker: recomputes a+b+c_in CHUNK bits per cycle and compares it with the DUT response.
// Optional first-mismatch capture is enabled by defining CHECKER_FIRST_ERR_CAPTURE_EN.
module adder_result_checker #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_c_out,
  output logic             done,
  output logic             match,
  output logic             pass,
  output logic [31:0]      vec_count,
  output logic [15:0]      err_count,
  output logic             first_err_valid,
  output logic [WIDTH:0]   first_err_exp
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CMP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] dut_sum_q;
  logic             dut_c_out_q;
  logic             carry_q;
  logic [IDXW-1:0]  idx_q;

  int               base;
  logic [CHUNK:0]   chunk_add;
  logic [WIDTH:0]   expected;
  logic             mismatch;

  // One CHUNK-wide slice of the ripple addition, selected by the chunk index.
  always_comb begin
    base      = int'(idx_q) * CHUNK;
    chunk_add = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, carry_q};
    expected  = {carry_q, sum_q};
    mismatch  = ({dut_c_out_q, dut_sum_q} != expected);
  end

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      dut_sum_q   <= '0;
      dut_c_out_q <= 1'b0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      done        <= 1'b0;
      match       <= 1'b0;
      pass        <= 1'b1;
      vec_count   <= '0;
      err_count   <= '0;
    end else if (clear) begin
      // Clear wins over acceptance and completion; an in-flight vector is dropped.
      state     <= IDLE;
      done      <= 1'b0;
      match     <= 1'b0;
      pass      <= 1'b1;
      vec_count <= '0;
      err_count <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q         <= a;
            b_q         <= b;
            dut_sum_q   <= dut_sum;
            dut_c_out_q <= dut_c_out;
            carry_q     <= c_in;
            sum_q       <= '0;
            idx_q       <= '0;
            state       <= CALC;
          end
        end
        CALC: begin
          sum_q[base +: CHUNK] <= chunk_add[CHUNK-1:0];
          carry_q              <= chunk_add[CHUNK];
          if (idx_q == LAST_IDX) begin
            state <= CMP;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        CMP: begin
          done      <= 1'b1;
          match     <= !mismatch;
          vec_count <= vec_count + 32'd1;
          if (mismatch) begin
            pass <= 1'b0;
            if (err_count != 16'hFFFF) begin
              err_count <= err_count + 16'd1;
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
  logic           first_err_valid_q;
  logic [WIDTH:0] first_err_exp_q;

  // Only the earliest mismatch since reset/clear is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_valid_q <= 1'b0;
      first_err_exp_q   <= '0;
    end else if (clear) begin
      first_err_valid_q <= 1'b0;
      first_err_exp_q   <= '0;
    end else if (state == CMP && mismatch && !first_err_valid_q) begin
      first_err_valid_q <= 1'b1;
      first_err_exp_q   <= expected;
    end
  end

  assign first_err_valid = first_err_valid_q;
  assign first_err_exp   = first_err_exp_q;
`else
  assign first_err_valid = 1'b0;
  assign first_err_exp   = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Self-checking bench for adder_result_checker: directed vectors with literal expectations plus
// randomized traffic compared every cycle against a countdown/arithmetic reference model.
module tb_adder_result_checker;

  localparam int WIDTH  = 64;
  localparam int CHUNK  = 16;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int LAT    = NCHUNK + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             c_in = 1'b0;
  logic [WIDTH-1:0] dut_sum = '0;
  logic             dut_c_out = 1'b0;
  logic             done;
  logic             match;
  logic             pass;
  logic [31:0]      vec_count;
  logic [15:0]      err_count;
  logic             first_err_valid;
  logic [WIDTH:0]   first_err_exp;

  int      checks_total  = 0;
  int      checks_passed = 0;
  longint  cycle = 0;
  bit      cmp_en = 1'b0;

  // Reference model: a vector completes LAT edges after the edge that accepts it.
  int             m_left;
  logic [WIDTH:0] m_exp;
  logic [WIDTH:0] m_obs;
  logic [WIDTH:0] m_fexp;
  logic           m_done;
  logic           m_match;
  logic           m_pass;
  logic           m_fev;
  logic [31:0]    m_vec;
  logic [15:0]    m_err;

  adder_result_checker #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .dut_sum(dut_sum), .dut_c_out(dut_c_out),
    .done(done), .match(match), .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_exp(first_err_exp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_exp <= '0; m_obs <= '0; m_fexp <= '0;
      m_done <= 1'b0; m_match <= 1'b0; m_pass <= 1'b1; m_fev <= 1'b0;
      m_vec <= '0; m_err <= '0;
    end else if (clear) begin
      m_left <= 0; m_fexp <= '0;
      m_done <= 1'b0; m_match <= 1'b0; m_pass <= 1'b1; m_fev <= 1'b0;
      m_vec <= '0; m_err <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left != 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done  <= 1'b1;
          m_match <= (m_obs == m_exp);
          m_vec   <= m_vec + 32'd1;
          if (m_obs != m_exp) begin
            m_pass <= 1'b0;
            if (m_err != 16'hFFFF) m_err <= m_err + 16'd1;
            if (!m_fev) begin
              m_fev  <= 1'b1;
              m_fexp <= m_exp;
            end
          end
        end
      end else if (in_valid) begin
        m_left <= LAT;
        m_exp  <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
        m_obs  <= {dut_c_out, dut_sum};
      end
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Every cycle, all outputs are held against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cyc_in_ready", 128'(in_ready), 128'(m_left == 0));
      checkOutput("cyc_done", 128'(done), 128'(m_done));
      if (m_done) checkOutput("cyc_match", 128'(match), 128'(m_match));
      checkOutput("cyc_pass", 128'(pass), 128'(m_pass));
      checkOutput("cyc_vec_count", 128'(vec_count), 128'(m_vec));
      checkOutput("cyc_err_count", 128'(err_count), 128'(m_err));
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
      checkOutput("cyc_first_err_valid", 128'(first_err_valid), 128'(m_fev));
      checkOutput("cyc_first_err_exp", 128'(first_err_exp), 128'(m_fexp));
`else
      checkOutput("cyc_first_err_valid", 128'(first_err_valid), 128'(0));
      checkOutput("cyc_first_err_exp", 128'(first_err_exp), 128'(0));
`endif
    end
  end

  task automatic applyStimulus(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                               input logic vc, input logic [WIDTH-1:0] vs, input logic vco);
    @(posedge clk); #2;
    a = va; b = vb; c_in = vc; dut_sum = vs; dut_c_out = vco; in_valid = 1'b1;
  endtask

  task automatic waitIdle();
    int guard = 0;
    while (m_left != 0 && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
  endtask

  // Done must be seen after the 5th edge following acceptance (6 edges counting the accepting one).
  task automatic runVector(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb, input logic vc,
                           input logic [WIDTH-1:0] vs, input logic vco, input logic exp_match,
                           input string tag);
    int n;
    waitIdle();
    applyStimulus(va, vb, vc, vs, vco);
    @(posedge clk); #2;
    in_valid = 1'b0;
    a = ~va; b = {$urandom, $urandom}; c_in = ~vc; dut_sum = ~vs; dut_c_out = ~vco;
    for (n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done === 1'b1) break;
    end
    checkOutput({tag, "_latency"}, 128'(n), 128'(LAT));
    checkOutput({tag, "_match"}, 128'(match), 128'(exp_match));
  endtask

  task automatic doClear();
    @(posedge clk); #2; clear = 1'b1;
    @(posedge clk); #2; clear = 1'b0;
    @(negedge clk);
  endtask

  logic [WIDTH-1:0] ones;
  logic [WIDTH:0]   rexp;
  longint           last_acc;
  int               k;
  int               guard;
  int               dones;

  initial begin
    ones = '1;
    $display("[TB] starting");
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1;
    cmp_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checkOutput("idle_done", 128'(done), 128'(0));
    end
    checkOutput("idle_in_ready", 128'(in_ready), 128'(1));
    checkOutput("idle_pass", 128'(pass), 128'(1));
    checkOutput("idle_vec", 128'(vec_count), 128'(0));
    checkOutput("idle_err", 128'(err_count), 128'(0));

    runVector('0, '0, 1'b0, '0, 1'b0, 1'b1, "zero");
    checkOutput("zero_vec", 128'(vec_count), 128'(1));
    checkOutput("zero_err", 128'(err_count), 128'(0));

    runVector(ones, 64'd1, 1'b0, '0, 1'b1, 1'b1, "carry_ok");
    runVector(ones, 64'd1, 1'b0, '0, 1'b0, 1'b0, "carry_bad");
    checkOutput("carry_bad_pass", 128'(pass), 128'(0));
    checkOutput("carry_bad_err", 128'(err_count), 128'(1));
    checkOutput("carry_bad_vec", 128'(vec_count), 128'(3));

    doClear();
    checkOutput("clear_vec", 128'(vec_count), 128'(0));
    checkOutput("clear_pass", 128'(pass), 128'(1));
    checkOutput("clear_first_valid", 128'(first_err_valid), 128'(0));

    runVector(64'd5, 64'd3, 1'b1, 64'd8, 1'b0, 1'b0, "five_three");
    runVector(ones, 64'd1, 1'b0, '0, 1'b0, 1'b0, "second_bad");
    checkOutput("second_bad_err", 128'(err_count), 128'(2));
`ifdef CHECKER_FIRST_ERR_CAPTURE_EN
    checkOutput("first_err_valid", 128'(first_err_valid), 128'(1));
    checkOutput("first_err_exp", 128'(first_err_exp), 128'(9));
`else
    checkOutput("first_err_valid_off", 128'(first_err_valid), 128'(0));
    checkOutput("first_err_exp_off", 128'(first_err_exp), 128'(0));
`endif

    // Back-to-back stream with in_valid held high; inputs move on right after each acceptance.
    doClear();
    k = 1;
    applyStimulus(64'(k), 64'(k), 1'b1, 64'(2 * k + 1), 1'b0);
    last_acc = 0;
    guard = 0;
    while (guard < 2000) begin
      @(posedge clk); #2;
      guard++;
      if (m_left == LAT) begin
        if (k > 1) checkOutput("stream_interval", 128'(cycle - last_acc), 128'(6));
        last_acc = cycle;
        k++;
        if (k > 100) break;
        a = 64'(k); b = 64'(k); c_in = k[0]; dut_sum = 64'(2 * k + (k % 2)); dut_c_out = 1'b0;
      end
    end
    checkOutput("stream_bounded", 128'(k), 128'(101));
    in_valid = 1'b0;
    repeat (LAT + 2) @(posedge clk);
    @(negedge clk);
    checkOutput("stream_vec", 128'(vec_count), 128'(100));
    checkOutput("stream_pass", 128'(pass), 128'(1));
    checkOutput("stream_err", 128'(err_count), 128'(0));

    // Randomized traffic, including carry chains crossing every chunk and occasional clears.
    for (int i = 0; i < 900; i++) begin
      @(posedge clk); #2;
      b = {$urandom, $urandom};
      a = ($urandom_range(3) == 0) ? ~b : {$urandom, $urandom};
      c_in = 1'($urandom);
      rexp = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
      if ($urandom_range(1) == 1) rexp[$urandom_range(WIDTH)] ^= 1'b1;
      {dut_c_out, dut_sum} = rexp;
      in_valid = 1'($urandom);
      clear = ($urandom_range(99) == 0);
    end
    in_valid = 1'b0; clear = 1'b0;
    waitIdle();

    // Reset pulse during CALC discards the vector.
    applyStimulus(64'd7, 64'd9, 1'b0, 64'd16, 1'b0);
    @(posedge clk); #2; in_valid = 1'b0;
    @(posedge clk); #2; rst_n = 1'b0;
    @(posedge clk); #2; rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_calc_ready", 128'(in_ready), 128'(1));
    checkOutput("rst_calc_vec", 128'(vec_count), 128'(0));
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkOutput("rst_calc_no_done", 128'(dones), 128'(0));

    // Clear during CALC likewise aborts without a done pulse.
    runVector(64'd1, 64'd2, 1'b0, 64'd3, 1'b0, 1'b1, "pre_clear");
    applyStimulus(64'd7, 64'd9, 1'b0, 64'd99, 1'b0);
    @(posedge clk); #2; in_valid = 1'b0;
    @(posedge clk); #2; clear = 1'b1;
    @(posedge clk); #2; clear = 1'b0;
    @(negedge clk);
    checkOutput("clr_calc_ready", 128'(in_ready), 128'(1));
    checkOutput("clr_calc_vec", 128'(vec_count), 128'(0));
    checkOutput("clr_calc_pass", 128'(pass), 128'(1));
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checkOutput("clr_calc_no_done", 128'(dones), 128'(0));
    checkOutput("clr_calc_err", 128'(err_count), 128'(0));

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
